model_arbiter: RTL and testbench

Round-robin scheduler that shares one `model` datapath instance (operand buses `i0[2:-2]`, `i1[-2:2]`; result buses `o0[2:-2]`, `o1[-2:2]`) between NREQ requesters. It sits between the requesters and the shared instance in `top`:
- accepts one request at a time via a valid/ready handshake;
- drives the instance operands and issues a start pulse;
- waits a fixed result latency, captures the results and returns them to the granted requester.

---
 rtl/model_arbiter_if.sv | 29 ++
 rtl/model_arbiter.sv | 134 +++++++++++++
 tb/tb_model_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/model_arbiter_if.sv
// Bundles the requester handshake, response and shared-instance buses of model_arbiter.
// master: requesters plus the shared instance; slave: the arbiter.
interface model_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [5*NREQ-1:0] req_i0;
  logic [5*NREQ-1:0] req_i1;
  logic [NREQ-1:0]   rsp_valid;
  logic [2:-2]       rsp_o0;
  logic [-2:2]       rsp_o1;
  logic              res_start;
  logic [2:-2]       res_i0;
  logic [-2:2]       res_i1;
  logic [2:-2]       res_o0;
  logic [-2:2]       res_o1;
  logic              busy;

  modport master (
    output req_valid, req_i0, req_i1, res_o0, res_o1,
    input  req_ready, rsp_valid, rsp_o0, rsp_o1, res_start, res_i0, res_i1, busy
  );

  modport slave (
    input  req_valid, req_i0, req_i1, res_o0, res_o1,
    output req_ready, rsp_valid, rsp_o0, rsp_o1, res_start, res_i0, res_i1, busy
  );
endinterface

// File: rtl/model_arbiter.sv
// Round-robin sharing of one model instance among NREQ requesters; result back LAT+2 cycles after accept.
// MODEL_ARB_GRANT_CNT_EN adds a saturating 16-bit grant_cnt output.
module model_arbiter #(
  parameter int NREQ = 2,
  parameter int LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef MODEL_ARB_GRANT_CNT_EN
  output logic [15:0] grant_cnt,
`endif
  model_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST   = PW'(NREQ - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_CAPTURE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, owner, winner;
  logic            found;
  logic            accept;
  logic [3:0]      cnt;
  logic [2:-2]     op0;
  logic [-2:2]     op1;
  logic [4:0]      sel_i0, sel_i1;
  logic [2:-2]     rsp0_q;
  logic [-2:2]     rsp1_q;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    logic [PW:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!found && bus.req_valid[idx[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_i0 = '0;
    sel_i1 = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (winner == PW'(k)) begin
        sel_i0 = bus.req_i0[5*k +: 5];
        sel_i1 = bus.req_i1[5*k +: 5];
      end
    end
  end

  assign accept = (state == ST_IDLE) && found;

  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.res_start = 1'b0;
    bus.res_i0    = '0;
    bus.res_i1    = '0;
    bus.busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        bus.busy = 1'b0;
        // Gated by rst_n so nothing looks accepted while reset is held.
        if (found && rst_n) bus.req_ready = NREQ'(1) << winner;
        if (found) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        bus.res_start = 1'b1;
        bus.res_i0    = op0;
        bus.res_i1    = op1;
        state_nxt     = ST_WAIT;
      end
      ST_WAIT: begin
        bus.res_i0 = op0;
        bus.res_i1 = op1;
        if (cnt == 4'd1) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        bus.rsp_valid = NREQ'(1) << owner;
        state_nxt     = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      owner  <= '0;
      cnt    <= '0;
      op0    <= '0;
      op1    <= '0;
      rsp0_q <= '0;
      rsp1_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op0   <= sel_i0;
        op1   <= sel_i1;
        owner <= winner;
        ptr   <= (winner == LAST) ? '0 : winner + PW'(1);
      end
      if (state == ST_ISSUE) cnt <= 4'(LAT);
      if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          rsp0_q <= bus.res_o0;
          rsp1_q <= bus.res_o1;
        end
      end
    end
  end

  assign bus.rsp_o0 = rsp0_q;
  assign bus.rsp_o1 = rsp1_q;

`ifdef MODEL_ARB_GRANT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) grant_cnt <= '0;
    else if (accept && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_model_arbiter.sv
// Directed bench for model_arbiter: one instance with LAT=1, one with LAT=4, both NREQ=2.
module tb_model_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic glitch = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  model_arbiter_if #(.NREQ(2)) ifa ();
  model_arbiter_if #(.NREQ(2)) ifb ();

  // Shared-instance stand-ins: o0 passes i0 through, o1 inverts i1.
  assign ifa.res_o0 = ifa.res_i0;
  assign ifa.res_o1 = ~ifa.res_i1;
  assign ifb.res_o0 = glitch ? ~ifb.res_i0 : ifb.res_i0;
  assign ifb.res_o1 = ~ifb.res_i1;

`ifdef MODEL_ARB_GRANT_CNT_EN
  logic [15:0] gc1, gc4;
`endif

  model_arbiter #(.NREQ(2), .LAT(1)) u1 (
`ifdef MODEL_ARB_GRANT_CNT_EN
    .grant_cnt(gc1),
`endif
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifa)
  );

  model_arbiter #(.NREQ(2), .LAT(4)) u4 (
`ifdef MODEL_ARB_GRANT_CNT_EN
    .grant_cnt(gc4),
`endif
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [1:0] exp_oh [3];
    logic [4:0] exp_o0 [3];
    logic [4:0] exp_o1 [3];
    int last;
    exp_oh = '{2'b01, 2'b10, 2'b01};
    exp_o0 = '{5'b10010, 5'b01001, 5'b10010};
    exp_o1 = '{5'b00111, 5'b11000, 5'b00111};
    last = 0;
    ifa.req_valid = '0; ifa.req_i0 = '0; ifa.req_i1 = '0;
    ifb.req_valid = '0; ifb.req_i0 = '0; ifb.req_i1 = '0;

    // Reset state
    #3;
    check("rst_busy", 32'(ifa.busy), 32'd0);
    check("rst_start", 32'(ifa.res_start), 32'd0);
    check("rst_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    check("rst_res_i0", 32'(ifa.res_i0), 32'd0);
    check("rst_rsp_o0", 32'(ifa.rsp_o0), 32'd0);
    ifa.req_valid = 2'b01;
    #1;
    check("rst_ready", 32'(ifa.req_ready), 32'd0);
    ifa.req_valid = '0;
    step();
    rst_n = 1'b1;

    // Single request
    ifa.req_i0 = {5'b00000, 5'b10110};
    ifa.req_i1 = {5'b00000, 5'b00011};
    ifa.req_valid = 2'b01;
    #1;
    check("single_ready", 32'(ifa.req_ready), 32'b01);
    step(); ifa.req_valid = '0; #1;
    check("single_start", 32'(ifa.res_start), 32'd1);
    check("single_res_i0", 32'(ifa.res_i0), 32'b10110);
    check("single_res_i1", 32'(ifa.res_i1), 32'b00011);
    step(); #1;
    check("single_wait_rsp", 32'(ifa.rsp_valid), 32'd0);
    check("single_wait_start", 32'(ifa.res_start), 32'd0);
    step(); #1;
    check("single_rsp_valid", 32'(ifa.rsp_valid), 32'b01);
    check("single_rsp_o0", 32'(ifa.rsp_o0), 32'b10110);
    check("single_rsp_o1", 32'(ifa.rsp_o1), 32'b11100);
    step(); #1;
    check("single_idle_rsp", 32'(ifa.rsp_valid), 32'd0);
    check("single_idle_busy", 32'(ifa.busy), 32'd0);
    check("single_hold_o0", 32'(ifa.rsp_o0), 32'b10110);

    // Fairness; the reset also returns ptr from 1 to 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ifa.req_i0 = {5'b01001, 5'b10010};
    ifa.req_i1 = {5'b00111, 5'b11000};
    ifa.req_valid = 2'b11;
    #1;
    for (int op = 0; op < 3; op++) begin
      for (int w = 0; w < 12 && ifa.req_ready == 2'b00; w++) step();
      check("fair_grant", 32'(ifa.req_ready), 32'(exp_oh[op]));
      if (op > 0) check("fair_gap", 32'(cyc - last), 32'd4);
      last = cyc;
      repeat (3) step();
      check("fair_rsp_valid", 32'(ifa.rsp_valid), 32'(exp_oh[op]));
      check("fair_rsp_o0", 32'(ifa.rsp_o0), 32'(exp_o0[op]));
      check("fair_rsp_o1", 32'(ifa.rsp_o1), 32'(exp_o1[op]));
      step();
    end
    ifa.req_valid = '0;
`ifdef MODEL_ARB_GRANT_CNT_EN
    check("grant_cnt_3", 32'(gc1), 32'd3);
    force u1.grant_cnt = 16'hFFFF;
    #1;
    release u1.grant_cnt;
`endif

    // Late/withdrawn request from requester 1 while requester 0 is served
    #1;
    ifa.req_valid = 2'b01;
    #1;
    check("late_ready0", 32'(ifa.req_ready), 32'b01);
    step(); ifa.req_valid = 2'b10; #1;
    check("late_ready_issue", 32'(ifa.req_ready), 32'd0);
`ifdef MODEL_ARB_GRANT_CNT_EN
    check("grant_cnt_sat", 32'(gc1), 32'hFFFF);
`endif
    step(); ifa.req_valid = '0; #1;
    check("late_ready_wait", 32'(ifa.req_ready), 32'd0);
    step(); #1;
    check("late_rsp_valid", 32'(ifa.rsp_valid), 32'b01);
    step(); #1;
    check("late_idle_busy", 32'(ifa.busy), 32'd0);
    check("late_idle_ready", 32'(ifa.req_ready), 32'd0);
    step(); #1;
    check("late_no_grant", 32'(ifa.busy), 32'd0);

    // Reset during WAIT
    ifa.req_valid = 2'b01;
    step(); ifa.req_valid = '0;
    step(); #1;
    check("mid_busy_before", 32'(ifa.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(ifa.busy), 32'd0);
    check("mid_res_i0", 32'(ifa.res_i0), 32'd0);
    check("mid_res_start", 32'(ifa.res_start), 32'd0);
    check("mid_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    check("mid_rsp_o0", 32'(ifa.rsp_o0), 32'd0);
    ifa.req_valid = 2'b10;
    step();
    check("mid_rsp_during_rst", 32'(ifa.rsp_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    check("mid_post_ready", 32'(ifa.req_ready), 32'b10);
    step(); ifa.req_valid = '0; #1;
    check("mid_post_res_i0", 32'(ifa.res_i0), 32'b01001);
    step(); #1;
    check("mid_no_stale_rsp", 32'(ifa.rsp_valid), 32'd0);
    step(); #1;
    check("mid_post_rsp", 32'(ifa.rsp_valid), 32'b10);
    step();

    // LAT=4 latency, with res_o0 disturbed on non-sampling WAIT cycles
    ifb.req_i0 = {5'b00000, 5'b01101};
    ifb.req_i1 = {5'b00000, 5'b10100};
    ifb.req_valid = 2'b01;
    #1;
    check("lat_ready", 32'(ifb.req_ready), 32'b01);
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) ifb.req_valid = '0;
      glitch = (k >= 2 && k <= 4);
      #1;
      check("lat_busy", 32'(ifb.busy), 32'(k <= 6));
      check("lat_rsp_valid", 32'(ifb.rsp_valid), (k == 6) ? 32'b01 : 32'd0);
    end
    check("lat_rsp_o0", 32'(ifb.rsp_o0), 32'b01101);
    check("lat_rsp_o1", 32'(ifb.rsp_o1), 32'b01011);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
